// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if
// Bundles the payload handshake and serial-line status of serial_frame_tx.
//   data_in  : parallel payload (DATA_WIDTH bits), master -> slave
//   in_valid : payload valid this cycle, master -> slave
//   in_ready : transmitter can accept a payload, slave -> master
//   tx       : serial line, idle high, slave -> master
//   busy     : frame in progress, slave -> master
//   done     : one-cycle pulse when a frame completes, slave -> master
interface serial_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  in_valid;
  logic                  in_ready;
  logic                  tx;
  logic                  busy;
  logic                  done;

  modport master (
    output data_in, in_valid,
    input  in_ready, tx, busy, done
  );

  modport slave (
    input  data_in, in_valid,
    output in_ready, tx, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Frames a parallel payload as start bit (0), DATA_WIDTH data bits LSB first,
// stop bit (1), each held CLKS_PER_BIT cycles, on a registered serial line.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; aborts any frame in progress
//   bus   : serial_frame_tx_if.slave (data_in/in_valid in; in_ready/tx/busy/done out)
// All outputs are registered; in_ready has no path from in_valid.
module serial_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  serial_frame_tx_if.slave  bus
);

  // Counter widths never drop to zero, even for CLKS_PER_BIT=1 / DATA_WIDTH=1.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  tx_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  in_ready_reg;

  // The bit on the line is always shift_reg[0]; the next bit is loaded
  // one edge early so tx changes exactly at the bit boundary.
  assign shift_next = shift_reg >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      in_ready_reg <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (bus.in_valid && in_ready_reg) begin
            shift_reg    <= bus.data_in;
            state_reg    <= START;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b0;
            cnt_reg      <= '0;
            idx_reg      <= '0;
          end
        end
        START: begin
          if (cnt_reg == CNT_MAX) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= DATA;
            tx_reg    <= shift_reg[0];
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_reg == CNT_MAX) begin
            cnt_reg <= '0;
            if (idx_reg == IDX_MAX) begin
              idx_reg   <= '0;
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + IDX_W'(1);
              shift_reg <= shift_next;
              tx_reg    <= shift_next[0];
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_reg == CNT_MAX) begin
            // The done cycle is already IDLE, so a new payload can be
            // accepted at the end of it.
            cnt_reg      <= '0;
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg    <= IDLE;
          tx_reg       <= 1'b1;
          busy_reg     <= 1'b0;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx       = tx_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.in_ready = in_ready_reg;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
// Two transmitters share clk/reset: dut0 with CLKS_PER_BIT=4, dut1 with
// CLKS_PER_BIT=1. A per-cycle monitor samples both on the falling edge,
// captures each frame and compares the decoded payload against the
// expectation queued when the payload was driven.
module tb_serial_frame_tx;
  localparam int W  = 8;
  localparam int C0 = 4;
  localparam int C1 = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_WIDTH(W)) bus0 ();
  serial_frame_tx_if #(.DATA_WIDTH(W)) bus1 ();

  serial_frame_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  serial_frame_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [W-1:0] exp_q [2][$];
  bit         samp [2][$];
  bit         in_frame [2];
  bit         expect_abort [2];
  bit         check_gap [2];
  int         idle_run [2];
  int         done_cnt [2];
  bit         mon_en = 1'b0;

  function automatic int cpb(input int id);
    return (id == 0) ? C0 : C1;
  endfunction

  function automatic logic get_tx(input int id);
    return (id == 0) ? bus0.tx : bus1.tx;
  endfunction
  function automatic logic get_busy(input int id);
    return (id == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic get_done(input int id);
    return (id == 0) ? bus0.done : bus1.done;
  endfunction
  function automatic logic get_ready(input int id);
    return (id == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic end_frame(input int id);
    int c;
    int len;
    bit steady;
    logic [W-1:0] data;
    c = cpb(id);
    len = samp[id].size();
    chk($sformatf("frame_len%0d", id), len, (W + 2) * c);
    if (len == (W + 2) * c) begin
      steady = 1'b1;
      for (int s = 0; s < W + 2; s++)
        for (int k = 0; k < c; k++)
          if (samp[id][s*c+k] != samp[id][s*c]) steady = 1'b0;
      chk($sformatf("slot_steady%0d", id), steady, 1);
      chk($sformatf("start_bit%0d", id), samp[id][0], 0);
      chk($sformatf("stop_bit%0d", id), samp[id][(W+1)*c], 1);
      for (int b = 0; b < W; b++) data[b] = samp[id][(b+1)*c];
      if (exp_q[id].size() == 0)
        chk($sformatf("extra_frame%0d", id), 1, 0);
      else
        chk($sformatf("payload%0d", id), data, exp_q[id].pop_front());
    end
  endtask

  task automatic monitor(input int id);
    logic tx, busy, done, rdy;
    tx = get_tx(id); busy = get_busy(id); done = get_done(id); rdy = get_ready(id);
    chk($sformatf("ready_vs_busy%0d", id), rdy, {31'b0, ~busy});
    if (done === 1'b1) done_cnt[id]++;
    if (busy === 1'b1) begin
      if (!in_frame[id]) begin
        in_frame[id] = 1'b1;
        samp[id].delete();
        if (check_gap[id]) chk($sformatf("b2b_gap%0d", id), idle_run[id], 1);
        check_gap[id] = 1'b0;
      end
      samp[id].push_back(tx);
      idle_run[id] = 0;
    end else begin
      idle_run[id]++;
      chk($sformatf("idle_tx%0d", id), tx, 1);
      if (in_frame[id]) begin
        in_frame[id] = 1'b0;
        if (expect_abort[id]) begin
          chk($sformatf("abort_no_done%0d", id), done, 0);
          expect_abort[id] = 1'b0;
        end else begin
          chk($sformatf("done_at_end%0d", id), done, 1);
          end_frame(id);
        end
      end else begin
        chk($sformatf("idle_done%0d", id), done, 0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) begin
      monitor(0);
      monitor(1);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic [W-1:0] d);
    if (id == 0) begin
      bus0.in_valid = v; bus0.data_in = d;
    end else begin
      bus1.in_valid = v; bus1.data_in = d;
    end
  endtask

  task automatic send(input int id, input logic [W-1:0] d);
    drive(id, 1'b1, d);
    exp_q[id].push_back(d);
    tick();
    chk($sformatf("accept_busy%0d", id), get_busy(id), 1);
    chk($sformatf("accept_tx%0d", id), get_tx(id), 0);
    drive(id, 1'b0, '0);
  endtask

  task automatic wait_done(input int id, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (get_done(id) === 1'b1) seen = 1'b1;
    end
    chk($sformatf("done_seen%0d", id), seen, 1);
  endtask

  initial begin
    int d0, d1, busy_seen;
    logic [W-1:0] junk;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // Reset state, then 20 idle cycles watched by the monitor.
    chk("rst_tx", bus0.tx, 1);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_ready", bus0.in_ready, 1);
    chk("rst_done", bus0.done, 0);
    chk("rst_busy1", bus1.busy, 0);
    repeat (20) tick();
    $display("[TB] reset/idle checked");

    // Single frame 8'hA5.
    d0 = done_cnt[0];
    send(0, 8'hA5);
    wait_done(0, 60);
    chk("a5_ready_at_done", bus0.in_ready, 1);
    chk("a5_done_pulses", done_cnt[0] - d0, 1);
    repeat (3) tick();
    $display("[TB] frame 8'hA5 sent");

    // Back-to-back frames with in_valid held high.
    d0 = done_cnt[0];
    drive(0, 1'b1, 8'h01);
    exp_q[0].push_back(8'h01);
    exp_q[0].push_back(8'hFF);
    tick();
    chk("b2b_accept1", bus0.busy, 1);
    drive(0, 1'b1, 8'hFF);
    wait_done(0, 60);
    check_gap[0] = 1'b1;
    tick();
    chk("b2b_accept2", bus0.busy, 1);
    drive(0, 1'b0, '0);
    wait_done(0, 60);
    repeat (5) tick();
    chk("b2b_done_pulses", done_cnt[0] - d0, 2);
    chk("b2b_queue_empty", exp_q[0].size(), 0);
    $display("[TB] back-to-back 8'h01, 8'hFF sent");

    // Inputs toggled mid-frame, plus a reset glitch between edges.
    send(0, 8'h3C);
    for (int i = 0; i < 30; i++) begin
      tick();
      drive(0, 1'($urandom_range(0, 1)), W'($urandom));
      if (i == 10) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
    end
    drive(0, 1'b0, '0);
    wait_done(0, 60);
    busy_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus0.busy !== 1'b0) busy_seen++;
    end
    chk("toggle_no_extra_frame", busy_seen, 0);
    $display("[TB] frame 8'h3C with toggling inputs sent");

    // Reset at cycle 15 of a frame, then a clean 8'h55.
    d0 = done_cnt[0];
    send(0, 8'h96);
    repeat (13) tick();
    reset = 1'b1;
    expect_abort[0] = 1'b1;
    junk = exp_q[0].pop_back();
    tick();
    reset = 1'b0;
    chk("abort_busy", bus0.busy, 0);
    chk("abort_tx", bus0.tx, 1);
    chk("abort_done", bus0.done, 0);
    repeat (3) tick();
    chk("abort_no_done_pulse", done_cnt[0] - d0, 0);
    send(0, 8'h55);
    wait_done(0, 60);
    $display("[TB] aborted frame, then 8'h55 sent (discarded %0h)", junk);

    // CLKS_PER_BIT=1: 8'h80, then reset racing in_valid.
    d1 = done_cnt[1];
    send(1, 8'h80);
    wait_done(1, 20);
    chk("c1_done_pulses", done_cnt[1] - d1, 1);
    reset = 1'b1;
    drive(1, 1'b1, 8'h42);
    tick();
    reset = 1'b0;
    drive(1, 1'b0, '0);
    chk("c1_rst_vs_valid_busy", bus1.busy, 0);
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus1.busy !== 1'b0) busy_seen++;
    end
    chk("c1_rst_vs_valid_no_frame", busy_seen, 0);
    chk("c1_queue_empty", exp_q[1].size(), 0);
    $display("[TB] CLKS_PER_BIT=1 frame 8'h80 and reset-priority checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of payload bits per frame (legal range 1..16).
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held (legal range 1..255).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 data_in  input  DATA_WIDTH  parallel payload to be framed and sent.
REQ-006 in_valid  input  1  data_in is valid this cycle.
REQ-007 in_ready  output  1  block can accept a payload this cycle.
REQ-008 tx  output  1  serial line; idle level 1.
REQ-009 busy  output  1  frame in progress.
REQ-010 done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; data_in SHALL be captured into an internal shift register at that edge.
REQ-012 in_ready SHALL be 1 only in state IDLE, and SHALL be driven from registered state (no combinational path from in_valid).
REQ-013 State machine states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on an accepted transfer; otherwise IDLE holds with tx=1.
REQ-015 START: tx=0 for exactly CLKS_PER_BIT cycles, then -> DATA.
REQ-016 DATA: DATA_WIDTH bits sent LSB first, each held exactly CLKS_PER_BIT cycles; after the last bit -> STOP.
REQ-017 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then -> IDLE.
REQ-018 tx SHALL be a registered output; the first START cycle on tx SHALL be the cycle after the accepting edge.
REQ-019 Frame length SHALL be exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles, from the first tx=0 cycle to the last STOP cycle inclusive.
REQ-020 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-021 done SHALL be 1 for exactly one cycle, the cycle the state returns to IDLE after STOP; at all other times 0.
REQ-022 in_ready SHALL be 1 in the same cycle done=1, so back-to-back frames are possible with no extra idle cycle: a new START may begin on the cycle after done.
REQ-023 in_valid and data_in changes while busy=1 SHALL be ignored; the captured payload SHALL NOT change mid-frame.
REQ-024 The bit-period counter SHALL be sized for CLKS_PER_BIT-1; the bit index counter SHALL be sized for DATA_WIDTH-1. Both SHALL reset to 0 at each bit/frame boundary, with no wrap-around artefacts.
REQ-025 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle.

Reset
REQ-026 When reset=1 at a rising edge: state=IDLE, tx=1, busy=0, done=0, in_ready=1 from the next cycle, and counters and shift register cleared to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame at that edge: tx=1 from the next cycle, and no done pulse.
REQ-028 Reset SHALL take priority over a simultaneous in_valid; that payload SHALL NOT be accepted.
REQ-029 reset has no asynchronous effect: a reset pulse between edges without a sampled 1 SHALL change nothing.

Verification
REQ-030 Reset then idle 20 cycles -> tx=1, busy=0, in_ready=1, done=0 throughout.
REQ-031 DATA_WIDTH=8, CLKS_PER_BIT=4, send 8'hA5 -> tx sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1; busy high for 40 cycles; done one pulse; in_ready back to 1.
REQ-032 in_valid held high with 8'h01 then 8'hFF -> the two frames are contiguous: the STOP of frame 1 is followed by the START of frame 2 the cycle after done, and there are exactly two done pulses.
REQ-033 Toggle data_in and in_valid during a frame of 8'h3C -> transmitted bits are still exactly 8'h3C LSB first, and no extra frame is sent.
REQ-034 Assert reset at cycle 15 of a frame -> tx=1 next cycle, busy=0, and no done pulse; a new 8'h55 sent afterwards is framed correctly.
REQ-035 CLKS_PER_BIT=1, send 8'h80 -> frame is 10 cycles: 0, seven 0s, 1, 1; reset asserted with in_valid=1 in the same edge -> no frame started.
